adc_capture: RTL and testbench
==============================

Name: adc_capture

Overview:
- Acquisition stage directly downstream of the main sequencer.
- On the sequencer's one-cycle start_sampling pulse, captures SAMPLES consecutive ADC words, converts them from offset-binary to sign-extended two's complement and writes them through the acquisition RAM write port that the FFT stage later reads.
- Reports completion with end_sampling.
- Also tracks the peak absolute sample and its index for echo gating.

Parameters:
- SAMPLES, 8192: words captured per acquisition; power of two.
- ADC_W, 10: ADC data width, offset-binary.
- DATA_W, 16: RAM word width; ADC_W < DATA_W.
- ADDR_W, 13: RAM address width; 2^ADDR_W == SAMPLES.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start_sampling  in  1  one-cycle start pulse from the sequencer.
- abort  in  1  level; cancels a capture in progress.
- decim  in  2  decimation select; keep every 2^decim-th sample; latched at start.
- adc_data  in  ADC_W  ADC output, valid every clk.
- mem_we  out  1  RAM write enable.
- mem_addr  out  ADDR_W  RAM write address.
- mem_wdata  out  DATA_W  converted sample.
- busy  out  1  high while ARMED or CAPTURE.
- end_sampling  out  1  one-cycle completion pulse.
- sample_count  out  ADDR_W+1  words written in the current or last capture.
- peak_abs  out  ADC_W-1  largest |sample| seen in the last capture.
- peak_idx  out  ADDR_W  address of the first occurrence of peak_abs.

Behaviour:
- Reset: all outputs are 0; state is IDLE; internal registers are cleared. Reset is asynchronous and overrides everything, including mid-capture; no end_sampling pulse is produced.
- adc_q: adc_data is registered every clk, giving a one-stage input pipe.
- Conversion: s = {~adc_q[ADC_W-1], adc_q[ADC_W-2:0]} as signed, sign-extended to DATA_W. Example: 0x200 -> 0; 0x3FF -> +511; 0x000 -> -512 (0xFE00).
- |s|: saturates at 2^(ADC_W-1)-1, so -512 counts as 511.

State machine (IDLE, ARMED, CAPTURE, DONE):
- IDLE:
  - start_sampling=1: latch decim into dsel, clear sample_count, peak_abs and peak_idx, set dcnt=0, go to ARMED.
  - Otherwise remain in IDLE.
- ARMED: one cycle to flush adc_q; go to CAPTURE.
- CAPTURE:
  - Each cycle dcnt increments modulo 2^dsel.
  - When dcnt==0: mem_we=1 next cycle, mem_addr=sample_count[ADDR_W-1:0], mem_wdata=s; sample_count increments.
  - Otherwise mem_we=0.
  - With dsel=0, writes are back to back. Word i holds adc_data sampled at the edge 2+i*2^dsel cycles after the start edge.
  - Peak update: if |s| > peak_abs (strictly greater), set peak_abs=|s| and peak_idx=address. Ties keep the earlier index.
  - After the write with address SAMPLES-1: go to DONE.
- DONE: end_sampling=1 for exactly one cycle, mem_we=0, go to IDLE.
- Output timing: mem_* are registered. mem_addr and mem_wdata hold their last value when mem_we=0.
- busy: asserted from the cycle after start is accepted until the DONE cycle (exclusive).
- start_sampling while not in IDLE: ignored, no restart.
- start_sampling in the DONE cycle: ignored.
- abort=1 in ARMED or CAPTURE: go to IDLE next cycle with mem_we=0 and no end_sampling pulse. sample_count keeps the partial count.
- abort and start_sampling both high in IDLE: abort wins and the start is ignored.
- sample_count: reaches SAMPLES (MSB set) at completion; it never wraps.
- decim changes during a capture have no effect.

Optional Feature:
- Macro: ADC_CLIP_COUNT_EN.
- Defined:
  - Adds output clip_count, 16 bits, reset 0, cleared at start.
  - Increments on each written sample whose adc_q is 0 or 2^ADC_W-1.
  - Saturates at 0xFFFF.
  - Same timing as sample_count.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Basic capture: reset, then pulse start with decim=0 and adc_data ramping 0..1023 repeating. Required: 8192 back-to-back writes, addr 0..8191; word0 = adc value 2 edges after start minus 512. end_sampling pulses once, one cycle after the addr 8191 write; sample_count=8192.
- Decimation: decim=2 with a ramp input. Required: consecutive written words differ by 4 (mod wrap); one write every 4 cycles; completes in about 32768 cycles; end_sampling pulses once.
- Peak tracking: constant 0x200 input, except 0x000 at word 100 and 0x3FF at word 200. Required: peak_abs=511, peak_idx=100 (tie keeps the earlier index).
- Abort: abort at word 50. Required: no further mem_we, no end_sampling pulse, sample_count=50, busy=0 the next cycle. A following start runs a full capture normally.
- Restart and reset interaction:
  - start_sampling re-pulsed mid-capture: ignored, and the capture still ends at addr 8191.
  - Async reset asserted mid-capture: all outputs go to 0 immediately with no end_sampling pulse.
- Clip count: with ADC_CLIP_COUNT_EN defined, inject 3 samples of 0x3FF and 2 samples of 0x000 during a capture. Required: clip_count=5 at end_sampling.

Source files
------------

// File: rtl/adc_capture.sv
// Acquisition stage: captures SAMPLES offset-binary ADC words, converts them to two's complement and
// streams them to the acquisition RAM while tracking the peak magnitude. Optional: ADC_CLIP_COUNT_EN.
module adc_capture #(
    parameter int SAMPLES = 8192,
    parameter int ADC_W   = 10,
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 13
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_sampling,
    input  logic              abort,
    input  logic [1:0]        decim,
    input  logic [ADC_W-1:0]  adc_data,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              busy,
    output logic              end_sampling,
    output logic [ADDR_W:0]   sample_count,
    output logic [ADC_W-2:0]  peak_abs,
    output logic [ADDR_W-1:0] peak_idx
`ifdef ADC_CLIP_COUNT_EN
    ,
    output logic [15:0]       clip_count
`endif
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    // Offset-binary to sign-extended two's complement: flip the MSB, then replicate it.
    function automatic logic [DATA_W-1:0] to_twos(input logic [ADC_W-1:0] raw);
        logic [ADC_W-1:0] s;
        s = {~raw[ADC_W-1], raw[ADC_W-2:0]};
        return {{(DATA_W-ADC_W){s[ADC_W-1]}}, s};
    endfunction

    // Magnitude of the converted sample; the most negative code saturates to the largest positive value.
    function automatic logic [ADC_W-2:0] abs_sat(input logic [ADC_W-1:0] raw);
        logic [ADC_W-2:0] mag;
        if (raw[ADC_W-1]) begin
            mag = raw[ADC_W-2:0];
        end else if (raw[ADC_W-2:0] == '0) begin
            mag = '1;
        end else begin
            mag = ~raw[ADC_W-2:0] + (ADC_W-1)'(1);
        end
        return mag;
    endfunction

    state_t            state_r;
    logic [ADC_W-1:0]  adc_q_r;
    logic [1:0]        dsel_r;
    logic [2:0]        dcnt_r;
    logic [ADDR_W:0]   iss_cnt_r;
    logic              take_r;
    logic [2:0]        dmask_s;
    logic [ADC_W-2:0]  abs_s;

    assign dmask_s = (3'd1 << dsel_r) - 3'd1;
    assign abs_s   = abs_sat(adc_q_r);

    // One-stage input pipe on the ADC bus.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            adc_q_r <= '0;
        end else begin
            adc_q_r <= adc_data;
        end
    end

    // Capture FSM: take_r marks a decimation slot; the RAM write follows one cycle later from adc_q_r.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            dsel_r       <= 2'd0;
            dcnt_r       <= 3'd0;
            iss_cnt_r    <= '0;
            take_r       <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            busy         <= 1'b0;
            end_sampling <= 1'b0;
            sample_count <= '0;
            peak_abs     <= '0;
            peak_idx     <= '0;
`ifdef ADC_CLIP_COUNT_EN
            clip_count   <= 16'd0;
`endif
        end else begin
            mem_we       <= 1'b0;
            end_sampling <= 1'b0;
            take_r       <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start_sampling && !abort) begin
                        dsel_r       <= decim;
                        dcnt_r       <= 3'd0;
                        iss_cnt_r    <= '0;
                        sample_count <= '0;
                        peak_abs     <= '0;
                        peak_idx     <= '0;
`ifdef ADC_CLIP_COUNT_EN
                        clip_count   <= 16'd0;
`endif
                        busy         <= 1'b1;
                        state_r      <= ARMED;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ARMED: begin
                    if (abort) begin
                        busy    <= 1'b0;
                        state_r <= IDLE;
                    end else begin
                        state_r <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (abort) begin
                        busy    <= 1'b0;
                        state_r <= IDLE;
                    end else if (sample_count[ADDR_W]) begin
                        busy         <= 1'b0;
                        end_sampling <= 1'b1;
                        state_r      <= DONE;
                    end else begin
                        dcnt_r <= (dcnt_r + 3'd1) & dmask_s;
                        if ((dcnt_r == 3'd0) && !iss_cnt_r[ADDR_W]) begin
                            take_r    <= 1'b1;
                            iss_cnt_r <= iss_cnt_r + (ADDR_W+1)'(1);
                        end
                        if (take_r) begin
                            mem_we       <= 1'b1;
                            mem_addr     <= sample_count[ADDR_W-1:0];
                            mem_wdata    <= to_twos(adc_q_r);
                            sample_count <= sample_count + (ADDR_W+1)'(1);
                            // Strictly greater keeps the first index on ties.
                            if (abs_s > peak_abs) begin
                                peak_abs <= abs_s;
                                peak_idx <= sample_count[ADDR_W-1:0];
                            end
`ifdef ADC_CLIP_COUNT_EN
                            if (((adc_q_r == '0) || (adc_q_r == '1)) && (clip_count != 16'hFFFF)) begin
                                clip_count <= clip_count + 16'd1;
                            end
`endif
                        end
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_capture.sv
// Randomized scoreboard bench for adc_capture: a cycle-indexed reference model queues expected RAM
// writes, and a negedge monitor pops and compares them as the DUT emits them.
module tb_adc_capture;

    localparam int SAMPLES = 8192;
    localparam int ADC_W   = 10;
    localparam int DATA_W  = 16;
    localparam int ADDR_W  = 13;

    logic              clk = 1'b0;
    logic              reset;
    logic              start_sampling;
    logic              abort;
    logic [1:0]        decim;
    logic [ADC_W-1:0]  adc_data;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              busy;
    logic              end_sampling;
    logic [ADDR_W:0]   sample_count;
    logic [ADC_W-2:0]  peak_abs;
    logic [ADDR_W-1:0] peak_idx;
`ifdef ADC_CLIP_COUNT_EN
    logic [15:0]       clip_count;
`endif

    adc_capture #(.SAMPLES(SAMPLES), .ADC_W(ADC_W), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .start_sampling(start_sampling), .abort(abort), .decim(decim),
        .adc_data(adc_data), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .end_sampling(end_sampling), .sample_count(sample_count),
        .peak_abs(peak_abs), .peak_idx(peak_idx)
`ifdef ADC_CLIP_COUNT_EN
        , .clip_count(clip_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int addr;
        int data;
    } wr_t;

    wr_t exp_q[$];

    // Model state (written only by the model process).
    int cyc;
    bit m_active, m_pend;
    int m_c0, m_d, m_next, m_wr, m_peak, m_pidx, m_clip, m_ready, m_exp_end, m_pend_raw;

    // Monitor state.
    int ends_seen, last_end_edge;
    int chk_mon, pass_mon;

    // Main state.
    int chk_main, pass_main;
    int c0, mode, ramp_v;
    bit rand_decim;

    // Reference model: word i is the ADC value at edge c0+2+i*D, written at the following edge.
    initial begin
        int k, v, a;
        cyc = 0; m_active = 0; m_pend = 0; m_ready = 0; m_exp_end = -1;
        m_c0 = 0; m_d = 1; m_next = 0; m_wr = 0; m_peak = 0; m_pidx = 0; m_clip = 0; m_pend_raw = 0;
        forever begin
            @(posedge clk);
            k = cyc;
            if (reset) begin
                m_active = 0; m_pend = 0; m_ready = 0; m_wr = 0;
                m_peak = 0; m_pidx = 0; m_clip = 0;
                exp_q.delete();
            end else if (m_active) begin
                if (abort) begin
                    m_active = 0; m_pend = 0; m_ready = k + 1;
                end else begin
                    if (m_pend) begin
                        v = m_pend_raw - 512;
                        exp_q.push_back('{addr: m_wr, data: v & 32'hFFFF});
                        a = (v < 0) ? -v : v;
                        if (a > 511) a = 511;
                        if (a > m_peak) begin m_peak = a; m_pidx = m_wr; end
                        if ((m_pend_raw == 0 || m_pend_raw == 1023) && m_clip < 65535) m_clip++;
                        m_wr++;
                        if (m_wr == SAMPLES) begin
                            m_active = 0; m_exp_end = k + 1; m_ready = k + 3;
                        end
                    end
                    m_pend = 0;
                    if (m_active && m_next < SAMPLES && k == m_c0 + 2 + m_next * m_d) begin
                        m_pend = 1; m_pend_raw = int'(adc_data); m_next++;
                    end
                end
            end else if (start_sampling && !abort && k >= m_ready) begin
                m_active = 1; m_c0 = k; m_d = 1 << decim; m_next = 0; m_wr = 0;
                m_peak = 0; m_pidx = 0; m_clip = 0; m_pend = 0;
            end
            cyc = cyc + 1;
        end
    end

    // Monitor: pop and compare on every RAM write, validate each end_sampling pulse.
    initial begin
        wr_t e;
        ends_seen = 0; last_end_edge = -1; chk_mon = 0; pass_mon = 0;
        forever begin
            @(negedge clk);
            if (mem_we) begin
                chk_mon++;
                if (exp_q.size() == 0) begin
                    $display("FAIL write_unexpected: addr=%0d data=%h, required no write", mem_addr, mem_wdata);
                end else begin
                    e = exp_q.pop_front();
                    if (int'(mem_addr) == e.addr && int'(mem_wdata) == e.data) pass_mon++;
                    else $display("FAIL write_data: addr=%0d data=%h, required addr=%0d data=%h",
                                  mem_addr, mem_wdata, e.addr, e.data[15:0]);
                end
            end
            if (end_sampling) begin
                ends_seen++;
                last_end_edge = cyc - 1;
                chk_mon++;
                if (last_end_edge == m_exp_end && exp_q.size() == 0) pass_mon++;
                else $display("FAIL end_timing: edge=%0d pending=%0d, required edge=%0d pending=0",
                              last_end_edge, exp_q.size(), m_exp_end);
            end
        end
    end

    task automatic chk(input bit ok, input string nm, input longint act, input longint req);
        chk_main++;
        if (ok) pass_main++;
        else $display("FAIL %s: got %0d, required %0d", nm, act, req);
    endtask

    task automatic step();
        int i;
        @(negedge clk);
        start_sampling = 1'b0;
        if (rand_decim) decim = 2'($urandom_range(3, 0));
        case (mode)
            0: begin adc_data = 10'(ramp_v); ramp_v = (ramp_v + 1) % 1024; end
            1: adc_data = 10'($urandom_range(1023, 0));
            default: begin
                i = cyc - c0 - 2;
                if (i == 100 || i == 400) adc_data = 10'h000;
                else if (i == 200 || i == 300 || i == 301) adc_data = 10'h3FF;
                else adc_data = 10'h200;
            end
        endcase
    endtask

    task automatic start_capture(input logic [1:0] d);
        step();
        start_sampling = 1'b1;
        decim = d;
        c0 = cyc;
        step();
    endtask

    task automatic run_until_end(input int budget, input string nm);
        int e0, n;
        e0 = ends_seen; n = 0;
        while (ends_seen == e0 && n < budget) begin
            step(); #1; n++;
        end
        chk(ends_seen == e0 + 1, nm, ends_seen - e0, 1);
    endtask

    task automatic check_zero(input string nm);
        chk(mem_we == 1'b0 && end_sampling == 1'b0 && busy == 1'b0, {nm, "_ctl"},
            {mem_we, end_sampling, busy}, 0);
        chk(mem_addr == '0 && mem_wdata == '0, {nm, "_mem"}, {mem_addr, mem_wdata}, 0);
        chk(sample_count == '0 && peak_abs == '0 && peak_idx == '0, {nm, "_stat"},
            {sample_count, peak_abs, peak_idx}, 0);
`ifdef ADC_CLIP_COUNT_EN
        chk(clip_count == 16'd0, {nm, "_clip"}, clip_count, 0);
`endif
    endtask

    task automatic check_stats(input string nm);
        chk(int'(sample_count) == m_wr, {nm, "_count"}, sample_count, m_wr);
        chk(int'(peak_abs) == m_peak, {nm, "_peak"}, peak_abs, m_peak);
        chk(int'(peak_idx) == m_pidx, {nm, "_pidx"}, peak_idx, m_pidx);
`ifdef ADC_CLIP_COUNT_EN
        chk(int'(clip_count) == m_clip, {nm, "_clip"}, clip_count, m_clip);
`endif
    endtask

    initial begin
        int e0;
        chk_main = 0; pass_main = 0; mode = 0; ramp_v = 0; rand_decim = 0; c0 = 0;
        reset = 1'b1; start_sampling = 1'b0; abort = 1'b0; decim = 2'd0; adc_data = '0;
        repeat (3) step();
        #1 check_zero("reset");
        step();
        reset = 1'b0;

        // Basic capture, ramp input, decim wiggling after start.
        mode = 0; rand_decim = 1;
        start_capture(2'd0);
        #1 chk(busy == 1'b1, "busy_after_start", busy, 1);
        run_until_end(9000, "basic_end");
        chk(last_end_edge == c0 + 4 + (SAMPLES - 1), "basic_end_edge", last_end_edge, c0 + 4 + SAMPLES - 1);
        chk(sample_count == 14'(SAMPLES), "basic_count", sample_count, SAMPLES);
        check_stats("basic");
        chk(busy == 1'b0, "basic_busy_done", busy, 0);
        step(); #1 chk(end_sampling == 1'b0, "basic_single_pulse", end_sampling, 0);

        // Decimation by 4.
        start_capture(2'd2);
        run_until_end(40000, "decim_end");
        chk(last_end_edge == c0 + 4 + (SAMPLES - 1) * 4, "decim_end_edge", last_end_edge, c0 + 4 + (SAMPLES - 1) * 4);
        chk(sample_count == 14'(SAMPLES), "decim_count", sample_count, SAMPLES);

        // Peak tracking with clip injections and an ignored mid-capture restart.
        mode = 2;
        start_capture(2'd0);
        for (int i = 0; i < 3000; i++) step();
        start_sampling = 1'b1;
        run_until_end(9000, "peak_end");
        chk(last_end_edge == c0 + 4 + (SAMPLES - 1), "restart_ignored_edge", last_end_edge, c0 + 4 + SAMPLES - 1);
        chk(peak_abs == 9'd511, "peak_abs", peak_abs, 511);
        chk(peak_idx == 13'd100, "peak_idx", peak_idx, 100);
`ifdef ADC_CLIP_COUNT_EN
        chk(clip_count == 16'd5, "clip_count", clip_count, 5);
`endif
        check_stats("peak");

        // Abort at word 50, random data.
        mode = 1;
        start_capture(2'd0);
        for (int n = 0; n < 200 && cyc != c0 + 53; n++) step();
        chk(cyc == c0 + 53, "abort_reach", cyc, c0 + 53);
        abort = 1'b1;
        e0 = ends_seen;
        step();
        abort = 1'b0;
        #1 chk(busy == 1'b0, "abort_busy", busy, 0);
        chk(sample_count == 14'd50, "abort_count", sample_count, 50);
        for (int i = 0; i < 20; i++) step();
        #1 chk(ends_seen == e0, "abort_no_end", ends_seen, e0);
        chk(sample_count == 14'd50, "abort_count_hold", sample_count, 50);

        // Abort beats start in IDLE.
        abort = 1'b1; start_sampling = 1'b1;
        step();
        abort = 1'b0;
        step(); #1 chk(busy == 1'b0, "abort_wins_start", busy, 0);

        // Full capture after abort.
        start_capture(2'd0);
        run_until_end(9000, "post_abort_end");
        chk(sample_count == 14'(SAMPLES), "post_abort_count", sample_count, SAMPLES);
        check_stats("post_abort");

        // Async reset mid-capture.
        start_capture(2'd0);
        for (int i = 0; i < 1000; i++) step();
        #1 chk(busy == 1'b1, "pre_reset_busy", busy, 1);
        #1 reset = 1'b1;
        #1 check_zero("mid_reset");
        e0 = ends_seen;
        repeat (3) step();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) step();
        #1 chk(ends_seen == e0, "reset_no_end", ends_seen, e0);
        chk(busy == 1'b0 && sample_count == '0, "reset_idle", {busy, sample_count}, 0);

        $display("%0d/%0d checks passed", pass_main + pass_mon, chk_main + chk_mon);
        $finish;
    end

endmodule
